// File: rtl/pacman_pkg.sv
// Shared definitions for the pacman mover: direction encodings, grid defaults
// and the sequencer state type.
package pacman_pkg;

  localparam int COORD_W    = 5;
  localparam int GRID_W_DEF = 28;
  localparam int GRID_H_DEF = 31;

  // One-hot direction requests, {L,R,U,D} bit order
  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_R = 4'b0100;
  localparam logic [3:0] DIR_U = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    Q_L,
    Q_R,
    Q_U,
    Q_D,
    CAPT
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] d);
    return (d == DIR_L) || (d == DIR_R) || (d == DIR_U) || (d == DIR_D);
  endfunction

endpackage

// File: rtl/neighbor_addr.sv
// Maps a tile and a one-hot direction to the neighbouring tile and whether it
// lies inside the maze. Horizontal edges wrap when TUNNEL_WRAP_EN is defined.
module neighbor_addr
  import pacman_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [3:0]         dir_i,
  output logic [COORD_W-1:0] nx_o,
  output logic [COORD_W-1:0] ny_o,
  output logic               in_grid_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  // A request that is not exactly one-hot never names a neighbour
  always_comb begin
    nx_o      = x_i;
    ny_o      = y_i;
    in_grid_o = 1'b0;
    case (dir_i)
      DIR_L: begin
        if (x_i != '0) begin
          nx_o      = x_i - 1'b1;
          in_grid_o = 1'b1;
        end
`ifdef TUNNEL_WRAP_EN
        else begin
          nx_o      = X_MAX;
          in_grid_o = 1'b1;
        end
`endif
      end
      DIR_R: begin
        if (x_i < X_MAX) begin
          nx_o      = x_i + 1'b1;
          in_grid_o = 1'b1;
        end
`ifdef TUNNEL_WRAP_EN
        else if (x_i == X_MAX) begin
          nx_o      = '0;
          in_grid_o = 1'b1;
        end
`endif
      end
      DIR_U: begin
        if (y_i != '0) begin
          ny_o      = y_i - 1'b1;
          in_grid_o = 1'b1;
        end
      end
      DIR_D: begin
        if (y_i < Y_MAX) begin
          ny_o      = y_i + 1'b1;
          in_grid_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pacman_mover.sv
// Tile-based mover: steps on tick, then re-reads the four neighbour walls from
// the maze ROM and publishes legal_moves atomically. Optional macro
// TUNNEL_WRAP_EN enables the horizontal tunnel (handled in neighbor_addr).
module pacman_mover
  import pacman_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int START_X = 13,
  parameter int START_Y = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [3:0]         curr_direction,
  output logic               wall_req,
  output logic [COORD_W-1:0] wall_x,
  output logic [COORD_W-1:0] wall_y,
  input  logic               wall_rdata,
  output logic [3:0]         legal_moves,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               move_done,
  output logic               moved,
  output logic               tick_overrun
);

  localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);

  state_e             state_q;
  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic [COORD_W-1:0] pos_x_d, pos_y_d;
  logic [3:1]         shadow_q;
  logic [3:0]         legal_q, legal_d;
  logic               qv_q;
  logic               init_q;
  logic               done_q;
  logic               moved_q;
  logic               moved_pend_q;
  logic               overrun_q;

  logic [COORD_W-1:0] mv_nx, mv_ny, q_nx, q_ny;
  logic               mv_in, q_in;
  logic [3:0]         q_dir;
  logic               step_ok;
  logic               cap_bit;

  neighbor_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_move_nb (
    .x_i       (pos_x_q),
    .y_i       (pos_y_q),
    .dir_i     (curr_direction),
    .nx_o      (mv_nx),
    .ny_o      (mv_ny),
    .in_grid_o (mv_in)
  );

  always_comb begin
    q_dir = 4'b0000;
    case (state_q)
      Q_L:     q_dir = DIR_L;
      Q_R:     q_dir = DIR_R;
      Q_U:     q_dir = DIR_U;
      Q_D:     q_dir = DIR_D;
      default: q_dir = 4'b0000;
    endcase
  end

  neighbor_addr #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_query_nb (
    .x_i       (pos_x_q),
    .y_i       (pos_y_q),
    .dir_i     (q_dir),
    .nx_o      (q_nx),
    .ny_o      (q_ny),
    .in_grid_o (q_in)
  );

  assign step_ok = is_onehot4(curr_direction) && |(curr_direction & legal_q) && mv_in;
  assign pos_x_d = step_ok ? mv_nx : pos_x_q;
  assign pos_y_d = step_ok ? mv_ny : pos_y_q;

  // Data returned this cycle belongs to last cycle's query; unqueried neighbours read as blocked
  assign cap_bit = qv_q & ~wall_rdata;
  assign legal_d = {shadow_q, cap_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      init_q       <= 1'b1;
      pos_x_q      <= START_X_C;
      pos_y_q      <= START_Y_C;
      shadow_q     <= '0;
      legal_q      <= '0;
      qv_q         <= 1'b0;
      done_q       <= 1'b0;
      moved_q      <= 1'b0;
      moved_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      qv_q   <= q_in;
      case (state_q)
        IDLE: begin
          if (init_q) begin
            init_q  <= 1'b0;
            state_q <= Q_L;
          end else if (tick) begin
            state_q <= MOVE;
          end
        end
        MOVE: begin
          pos_x_q      <= pos_x_d;
          pos_y_q      <= pos_y_d;
          moved_pend_q <= step_ok;
          state_q      <= Q_L;
        end
        Q_L: state_q <= Q_R;
        Q_R: begin
          shadow_q[3] <= cap_bit;
          state_q     <= Q_U;
        end
        Q_U: begin
          shadow_q[2] <= cap_bit;
          state_q     <= Q_D;
        end
        Q_D: begin
          shadow_q[1] <= cap_bit;
          state_q     <= CAPT;
        end
        CAPT: begin
          legal_q <= legal_d;
          moved_q <= moved_pend_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (tick && (state_q != IDLE || init_q)) overrun_q <= 1'b1;
    end
  end

  assign wall_req     = q_in;
  assign wall_x       = q_nx;
  assign wall_y       = q_ny;
  assign legal_moves  = legal_q;
  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign move_done    = done_q;
  assign moved        = moved_q;
  assign tick_overrun = overrun_q;

endmodule
